// File: rtl/exec_wb_stage_if.sv
// Bundle for exec_wb_stage: decode-side op handshake, ALU operand/result path and
// register-file writeback handshake. The stage uses the slave view.
interface exec_wb_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPC_W-1:0]      in_opcode;
    logic [DATA_W-1:0]     in_a;
    logic [DATA_W-1:0]     in_b;
    logic [REG_ADDR_W-1:0] in_dest;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [OPC_W-1:0]      alu_opcode;
    logic [DATA_W-1:0]     alu_c;
    logic                  alu_carry;
    logic                  alu_flag;
    logic                  alu_low;
    logic                  alu_negative;
    logic                  alu_zero;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_data;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_dest,
        output in_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
        output wb_valid, wb_dest, wb_data,
        input  wb_ready
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_dest,
        input  in_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
        input  wb_valid, wb_dest, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: registers ops into the ALU, captures result/flags, keeps the PSR.
// Optional macro EXEC_ILLEGAL_TRAP_EN: undefined opcodes set a sticky illegal_op flag.
module exec_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 8
) (
    input  logic           clk,
    input  logic           reset,
    exec_wb_stage_if.slave bus,
    output logic [4:0]     psr,
    output logic           illegal_op
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [OPC_W-1:0] OPC_ADD_LAST   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OPC_SUB_LAST   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OPC_CMP_LAST   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OPC_LOGIC_LAST = OPC_W'(21);
    localparam logic [OPC_W-1:0] OPC_NOP        = OPC_W'(22);

    function automatic logic is_add(input logic [OPC_W-1:0] opc);
        return opc <= OPC_ADD_LAST;
    endfunction

    function automatic logic is_sub(input logic [OPC_W-1:0] opc);
        return (opc > OPC_ADD_LAST) && (opc <= OPC_SUB_LAST);
    endfunction

    function automatic logic is_cmp(input logic [OPC_W-1:0] opc);
        return (opc > OPC_SUB_LAST) && (opc <= OPC_CMP_LAST);
    endfunction

    function automatic logic is_wb(input logic [OPC_W-1:0] opc);
        return (opc <= OPC_LOGIC_LAST) && !is_cmp(opc);
    endfunction

    // PSR layout {N,Z,F,L,C}; only the bits owned by the op class are replaced,
    // so don't-care flag values from the ALU never reach the register.
    function automatic logic [4:0] psr_upd(input logic [4:0] p, input logic [OPC_W-1:0] opc,
                                           input logic c, input logic f, input logic l,
                                           input logic n, input logic z);
        logic [4:0] r;
        r = p;
        if (is_add(opc)) begin
            r[0] = c;
            r[2] = f;
            r[3] = z;
        end else if (is_sub(opc)) begin
            r[2] = f;
            r[3] = z;
        end else if (is_cmp(opc)) begin
            r[1] = l;
            r[3] = z;
            r[4] = n;
        end
        return r;
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [REG_ADDR_W-1:0] dest_p0;

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = is_wb(bus.alu_opcode) ? HOLD : IDLE;
            end
            HOLD: begin
                bus.in_ready = bus.wb_ready;
                if (bus.wb_ready) state_nxt = bus.in_valid ? EXEC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = bus.in_valid & bus.in_ready;

    // p0: operands latched into the ALU on accept
    always_ff @(posedge clk) begin
        if (accept) dest_p0 <= bus.in_dest;
    end

    // p1: ALU outputs sampled in EXEC; writeback held until the register file takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_opcode <= OPC_NOP;
            bus.wb_valid   <= 1'b0;
            bus.wb_dest    <= '0;
            bus.wb_data    <= '0;
            psr            <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.alu_a      <= bus.in_a;
                bus.alu_b      <= bus.in_b;
                bus.alu_opcode <= bus.in_opcode;
            end
            if (state == EXEC) begin
                psr <= psr_upd(psr, bus.alu_opcode, bus.alu_carry, bus.alu_flag,
                               bus.alu_low, bus.alu_negative, bus.alu_zero);
                if (is_wb(bus.alu_opcode)) begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_data  <= bus.alu_c;
                    bus.wb_dest  <= dest_p0;
                end
            end
            if ((state == HOLD) && bus.wb_ready) bus.wb_valid <= 1'b0;
        end
    end

`ifdef EXEC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if ((state == EXEC) && (bus.alu_opcode > OPC_NOP)) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign illegal_op = 1'b0;
`endif
endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: directed scenarios followed by randomized ops checked against
// a transaction-level model (expected writebacks queue plus PSR/illegal flag model).
module tb_exec_wb_stage;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int OPC_W      = 8;
`ifdef EXEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] psr;
    logic       illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exec_wb_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OPC_W(OPC_W)) bus ();

    exec_wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OPC_W(OPC_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .psr(psr), .illegal_op(illegal_op)
    );

    function automatic logic [15:0] op_result(input logic [7:0] opc, input logic [15:0] a,
                                              input logic [15:0] b);
        case (opc)
            8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7: return a + b;
            8'd8, 8'd9, 8'd10, 8'd11: return a - b;
            8'd12: return a & b;
            8'd13: return a | b;
            8'd14: return a ^ b;
            8'd15: return ~a;
            8'd16: return a << b[3:0];
            8'd17: return a >> b[3:0];
            8'd18: return a & ~b;
            8'd19: return ~(a | b);
            8'd20: return ~(a & b);
            8'd21: return ~(a ^ b);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stand-in; flags a class does not own are X or junk so improper capture shows up
    logic [16:0] stub_sum;
    logic [16:0] stub_dif;
    always_comb begin
        stub_sum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        stub_dif         = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_c        = op_result(bus.alu_opcode, bus.alu_a, bus.alu_b);
        bus.alu_carry    = stub_sum[16];
        bus.alu_flag     = (bus.alu_a[15] == bus.alu_b[15]) && (stub_sum[15] != bus.alu_a[15]);
        bus.alu_low      = bus.alu_a < bus.alu_b;
        bus.alu_negative = $signed(bus.alu_a) < $signed(bus.alu_b);
        bus.alu_zero     = (bus.alu_c == 16'h0000);
        if (bus.alu_opcode <= 8'd7) begin
            bus.alu_low      = 1'bx;
            bus.alu_negative = 1'bx;
        end else if (bus.alu_opcode <= 8'd11) begin
            bus.alu_flag = (bus.alu_a[15] != bus.alu_b[15]) && (stub_dif[15] != bus.alu_a[15]);
            if (bus.alu_opcode <= 8'd9) begin
                bus.alu_carry    = 1'bx;
                bus.alu_low      = 1'bx;
                bus.alu_negative = 1'bx;
            end
        end
    end

    // Reference PSR rules {N,Z,F,L,C} computed with integer arithmetic
    function automatic logic [4:0] model_psr(input logic [4:0] p, input logic [7:0] opc,
                                             input logic [15:0] a, input logic [15:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        logic [4:0] n = p;
        if (opc <= 8'd7) begin
            r    = ua + ub;
            n[0] = (r > 65535);
            n[3] = ((r % 65536) == 0);
            r    = sa + sb;
            n[2] = (r > 32767) || (r < -32768);
        end else if (opc <= 8'd9) begin
            r    = sa - sb;
            n[2] = (r > 32767) || (r < -32768);
            n[3] = (ua == ub);
        end else if (opc <= 8'd11) begin
            n[1] = (ua < ub);
            n[4] = (sa < sb);
            n[3] = (ua == ub);
        end
        return n;
    endfunction

    function automatic bit model_wb(input logic [7:0] opc);
        return (opc <= 8'd9) || ((opc >= 8'd12) && (opc <= 8'd21));
    endfunction

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] data;
        logic [4:0]  psr;
    } wb_t;

    wb_t        q[$];
    logic [4:0] m_psr;
    logic       m_ill;
    int         rnd_wbs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] d);
        bus.in_valid  = v;
        bus.in_opcode = opc;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_dest   = d;
    endtask

    // Called with inputs settled for this cycle, before the next rising edge
    task automatic observe();
        wb_t e;
        if (bus.wb_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("rnd_spurious_wb", {31'd0, bus.wb_valid}, 32'd0);
            end else begin
                chk("rnd_hold_psr", {27'd0, psr}, {27'd0, q[0].psr});
                if (bus.wb_ready) begin
                    chk("rnd_wb_dest", {28'd0, bus.wb_dest}, {28'd0, q[0].dest});
                    chk("rnd_wb_data", {16'd0, bus.wb_data}, {16'd0, q[0].data});
                    void'(q.pop_front());
                    rnd_wbs++;
                end
            end
        end
        if (bus.in_valid && (bus.in_ready === 1'b1)) begin
            m_psr = model_psr(m_psr, bus.in_opcode, bus.in_a, bus.in_b);
            if (bus.in_opcode > 8'd22) m_ill = TRAP;
            if (model_wb(bus.in_opcode)) begin
                e.dest = bus.in_dest;
                e.data = op_result(bus.in_opcode, bus.in_a, bus.in_b);
                e.psr  = m_psr;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        int nxt;
        int seen;
        int last_wb;
        logic rdy;
        logic [7:0] ropc;

        reset        = 1'b1;
        bus.wb_ready = 1'b0;
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        cyc();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_dest", {28'd0, bus.wb_dest}, 32'd0);
        chk("rst_wb_data", {16'd0, bus.wb_data}, 32'd0);
        chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, bus.alu_b}, 32'd0);
        chk("rst_alu_opcode", {24'd0, bus.alu_opcode}, 32'd22);
        chk("rst_psr", {27'd0, psr}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        reset        = 1'b0;
        bus.wb_ready = 1'b1;

        // ADD overflow into the sign bit
        drive(1'b1, 8'd0, 16'h7FFF, 16'h0001, 4'd3);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        chk("add_alu_a", {16'd0, bus.alu_a}, 32'h7FFF);
        chk("add_exec_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("add_exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
        cyc();
        chk("add_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("add_wb_data", {16'd0, bus.wb_data}, 32'h8000);
        chk("add_wb_dest", {28'd0, bus.wb_dest}, 32'd3);
        chk("add_psr", {27'd0, psr}, 32'b00100);
        cyc();
        chk("add_retired", {31'd0, bus.wb_valid}, 32'd0);
        chk("add_idle_ready", {31'd0, bus.in_ready}, 32'd1);

        // ADDU wrap to zero, then CMP with no writeback
        drive(1'b1, 8'd1, 16'hFFFF, 16'h0001, 4'd4);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("addu_wb_data", {16'd0, bus.wb_data}, 32'h0000);
        chk("addu_psr", {27'd0, psr}, 32'b01001);
        cyc();
        drive(1'b1, 8'd10, 16'h0003, 16'hFFFF, 4'd7);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("cmp_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("cmp_idle", {31'd0, bus.in_ready}, 32'd1);
        chk("cmp_psr", {27'd0, psr}, 32'b00011);

        // AND under backpressure, then retire and accept on the same edge
        bus.wb_ready = 1'b0;
        drive(1'b1, 8'd12, 16'h00F0, 16'h0F0F, 4'd5);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("and_hold_valid", {31'd0, bus.wb_valid}, 32'd1);
            chk("and_hold_data", {16'd0, bus.wb_data}, 32'h0000);
            chk("and_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("and_hold_psr", {27'd0, psr}, 32'b00011);
            cyc();
        end
        bus.wb_ready = 1'b1;
        drive(1'b1, 8'd0, 16'h0001, 16'h0002, 4'd6);
        #1;
        chk("and_release_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        chk("and_retired", {31'd0, bus.wb_valid}, 32'd0);
        chk("and_next_alu_a", {16'd0, bus.alu_a}, 32'h0001);
        cyc();
        chk("and_next_wb_data", {16'd0, bus.wb_data}, 32'h0003);
        chk("and_next_wb_dest", {28'd0, bus.wb_dest}, 32'd6);
        chk("and_next_psr", {27'd0, psr}, 32'b00010);
        cyc();

        // Four back-to-back ADDIs with in_valid held high
        nxt     = 0;
        seen    = 0;
        last_wb = -1;
        for (int c = 0; c < 12; c++) begin
            if (nxt < 4) drive(1'b1, 8'd4, 16'(16'h1000 * nxt), 16'(nxt + 1), 4'(8 + nxt));
            else drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
            #1;
            rdy = bus.in_ready;
            if (bus.wb_valid === 1'b1) begin
                chk("b2b_dest", {28'd0, bus.wb_dest}, 32'(8 + seen));
                chk("b2b_data", {16'd0, bus.wb_data}, 32'(16'h1000 * seen + seen + 1));
                if (last_wb >= 0) chk("b2b_spacing", 32'(c - last_wb), 32'd2);
                last_wb = c;
                seen++;
            end
            cyc();
            if (rdy && (nxt < 4)) nxt++;
        end
        chk("b2b_count", 32'(seen), 32'd4);

        // Reset while holding a writeback
        bus.wb_ready = 1'b0;
        drive(1'b1, 8'd0, 16'h0010, 16'h0020, 4'd9);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("rsthold_pre_valid", {31'd0, bus.wb_valid}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("rsthold_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rsthold_psr", {27'd0, psr}, 32'd0);
        chk("rsthold_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset        = 1'b0;
        bus.wb_ready = 1'b1;
        cyc();
        cyc();
        chk("rsthold_dropped", {31'd0, bus.wb_valid}, 32'd0);

        // Undefined opcode between two ADDs
        drive(1'b1, 8'd0, 16'h8000, 16'h8000, 4'd1);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("ill_pre_psr", {27'd0, psr}, 32'b01101);
        cyc();
        drive(1'b1, 8'h40, 16'h1234, 16'h5678, 4'd2);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("ill_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("ill_psr", {27'd0, psr}, 32'b01101);
        chk("ill_flag", {31'd0, illegal_op}, {31'd0, TRAP});
        drive(1'b1, 8'd0, 16'h0005, 16'h0006, 4'd2);
        cyc();
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        cyc();
        chk("ill_next_data", {16'd0, bus.wb_data}, 32'd11);
        chk("ill_next_dest", {28'd0, bus.wb_dest}, 32'd2);
        chk("ill_next_psr", {27'd0, psr}, 32'b00000);
        chk("ill_sticky", {31'd0, illegal_op}, {31'd0, TRAP});
        cyc();

        // Randomized ops with random valid/backpressure against the model
        m_psr   = 5'b00000;
        m_ill   = TRAP;
        rnd_wbs = 0;
        for (int c = 0; c < 400; c++) begin
            ropc = (($urandom % 8) == 0) ? 8'(23 + $urandom_range(0, 232)) : 8'($urandom_range(0, 22));
            drive(1'($urandom % 3 != 0), ropc, 16'($urandom), 16'($urandom), 4'($urandom));
            if (($urandom % 4) == 0) drive(bus.in_valid, bus.in_opcode, 16'hFFFF, 16'h0001, bus.in_dest);
            bus.wb_ready = 1'($urandom % 4 != 0);
            #1;
            observe();
            cyc();
        end
        drive(1'b0, 8'd0, 16'h0, 16'h0, 4'h0);
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            observe();
            cyc();
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_final_psr", {27'd0, psr}, {27'd0, m_psr});
        chk("rnd_final_illegal", {31'd0, illegal_op}, {31'd0, m_ill});
        chk("rnd_some_wbs", 32'(rnd_wbs > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
